// File: rtl/cpu_control_unit.sv
// cpu_control_unit: fetch/decode/execute sequencer for the 8-bit-address, 16-bit-word accumulator CPU.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   run_i              execute enable, sampled at instruction boundaries
//   opcode_i           IR output, valid from DEC onward
//   acc_sign_i         ACC[15], used by JMPGEZ
//   mem_ready_i        memory completes the pending read/write this cycle
//   mem_rd_o/mem_wr_o  memory requests (address = MAR, write data = MBR)
//   mar_ld_o/mar_sel_o MAR load, source 0 = PC, 1 = MBR[7:0]
//   mbr_ld_mem_o       MBR <= memory data;  mbr_ld_acc_o  MBR <= ACC
//   pc_inc_o/pc_ld_o   PC increment / PC <= MBR[7:0]
//   ir_ld_o, br_ld_o, acc_ld_o  register load strobes
//   alu_op_o           0 PASS_B,1 ADD,2 SUB,3 AND,4 OR,5 NOT,6 SHR,7 SHL
//   halted_o, illegal_o, bus_err_o  sticky status until reset
//   instr_count_o      retired instruction count (wrapping)
module cpu_control_unit #(
  parameter int OPC_W   = 8,
  parameter int ALUOP_W = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               run_i,
  input  logic [OPC_W-1:0]   opcode_i,
  input  logic               acc_sign_i,
  input  logic               mem_ready_i,
  output logic               mem_rd_o,
  output logic               mem_wr_o,
  output logic               mar_ld_o,
  output logic               mar_sel_o,
  output logic               mbr_ld_mem_o,
  output logic               mbr_ld_acc_o,
  output logic               pc_inc_o,
  output logic               pc_ld_o,
  output logic               ir_ld_o,
  output logic               br_ld_o,
  output logic               acc_ld_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               halted_o,
  output logic               illegal_o,
  output logic               bus_err_o,
  output logic [CNT_W-1:0]   instr_count_o
);
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_F1   = 4'd1;
  localparam logic [3:0] S_F2   = 4'd2;
  localparam logic [3:0] S_F3   = 4'd3;
  localparam logic [3:0] S_DEC  = 4'd4;
  localparam logic [3:0] S_RD   = 4'd5;
  localparam logic [3:0] S_BRL  = 4'd6;
  localparam logic [3:0] S_EX   = 4'd7;
  localparam logic [3:0] S_WR1  = 4'd8;
  localparam logic [3:0] S_WR2  = 4'd9;
  localparam logic [3:0] S_JP   = 4'd10;
  localparam logic [3:0] S_END  = 4'd11;
  localparam logic [3:0] S_HLT  = 4'd12;

  logic [3:0]         state_q, state_d;
  logic [15:0]        wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               illegal_q, illegal_d, bus_err_q, bus_err_d;
  logic               in_wait, timeout, retire;
  logic               op_load, op_store, op_add, op_sub, op_and, op_or, op_jmp, op_jgez;
  logic               op_not, op_shr, op_shl, op_nop, op_halt, op_rd, op_ex, op_known;
  logic [ALUOP_W-1:0] alu_sel;

  assign op_nop   = opcode_i == OPC_W'(8'h00);
  assign op_load  = opcode_i == OPC_W'(8'h01);
  assign op_store = opcode_i == OPC_W'(8'h02);
  assign op_add   = opcode_i == OPC_W'(8'h03);
  assign op_sub   = opcode_i == OPC_W'(8'h04);
  assign op_jmp   = opcode_i == OPC_W'(8'h05);
  assign op_jgez  = opcode_i == OPC_W'(8'h06);
  assign op_and   = opcode_i == OPC_W'(8'h08);
  assign op_or    = opcode_i == OPC_W'(8'h09);
  assign op_not   = opcode_i == OPC_W'(8'h0A);
  assign op_shr   = opcode_i == OPC_W'(8'h0B);
  assign op_shl   = opcode_i == OPC_W'(8'h0C);
  assign op_halt  = opcode_i == OPC_W'(8'h0D);
  assign op_rd    = op_load | op_add | op_sub | op_and | op_or;
  assign op_ex    = op_not | op_shr | op_shl;
  assign op_known = op_rd | op_ex | op_store | op_jmp | op_jgez | op_nop | op_halt;

  assign alu_sel = op_add ? ALUOP_W'(1) : op_sub ? ALUOP_W'(2) : op_and ? ALUOP_W'(3) :
                   op_or  ? ALUOP_W'(4) : op_not ? ALUOP_W'(5) : op_shr ? ALUOP_W'(6) :
                   op_shl ? ALUOP_W'(7) : ALUOP_W'(0);

  assign in_wait = state_q == S_F2 || state_q == S_RD || state_q == S_WR2;
  // mem_ready on the last allowed wait cycle still completes the access
  assign timeout = in_wait && !mem_ready_i && wait_q == 16'(TIMEOUT - 1);

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q | timeout;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: state_d = run_i ? S_F1 : S_IDLE;
      S_F1:   state_d = S_F2;
      S_F2:   state_d = mem_ready_i ? S_F3 : timeout ? S_HLT : S_F2;
      S_F3:   state_d = S_DEC;
      S_DEC: begin
        state_d   = op_rd ? S_RD : op_store ? S_WR1 : op_ex ? S_EX : op_jmp ? S_JP :
                    op_jgez ? (acc_sign_i ? S_END : S_JP) : op_nop ? S_END : S_HLT;
        illegal_d = illegal_q | ~op_known;
        retire    = op_halt;
      end
      S_RD:   state_d = mem_ready_i ? S_BRL : timeout ? S_HLT : S_RD;
      S_BRL:  state_d = S_EX;
      S_EX:   state_d = S_END;
      S_WR1:  state_d = S_WR2;
      S_WR2:  state_d = mem_ready_i ? S_END : timeout ? S_HLT : S_WR2;
      S_JP:   state_d = S_END;
      S_END: begin
        state_d = run_i ? S_F1 : S_IDLE;
        retire  = 1'b1;
      end
      S_HLT:  state_d = S_HLT;
      default: state_d = S_IDLE;
    endcase
  end

  // wait counter restarts whenever a wait state is freshly entered
  assign wait_d = (in_wait && state_d == state_q) ? wait_q + 16'd1 : 16'd0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_q + CNT_W'(retire);
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign mem_rd_o      = state_q == S_F2 || state_q == S_RD;
  assign mem_wr_o      = state_q == S_WR2;
  assign mar_ld_o      = state_q == S_F1 || state_q == S_F3;
  assign mar_sel_o     = state_q == S_F3;
  assign mbr_ld_mem_o  = mem_rd_o && mem_ready_i;
  assign mbr_ld_acc_o  = state_q == S_WR1;
  assign pc_inc_o      = state_q == S_F2 && mem_ready_i;
  assign pc_ld_o       = state_q == S_JP;
  assign ir_ld_o       = state_q == S_F3;
  assign br_ld_o       = state_q == S_BRL;
  assign acc_ld_o      = state_q == S_EX;
  assign alu_op_o      = (state_q == S_EX) ? alu_sel : '0;
  assign halted_o      = state_q == S_HLT;
  assign illegal_o     = illegal_q;
  assign bus_err_o     = bus_err_q;
  assign instr_count_o = cnt_q;
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: scoreboard bench for cpu_control_unit (TIMEOUT=4).
module tb_cpu_control_unit;
  localparam logic [33:0] E_ACC   = 34'h1;
  localparam logic [33:0] E_BR    = 34'h2;
  localparam logic [33:0] E_IR    = 34'h4;
  localparam logic [33:0] E_PCLD  = 34'h8;
  localparam logic [33:0] E_PCINC = 34'h10;
  localparam logic [33:0] E_MBRA  = 34'h20;
  localparam logic [33:0] E_MBRM  = 34'h40;
  localparam logic [33:0] E_MSEL  = 34'h80;
  localparam logic [33:0] E_MARLD = 34'h100;
  localparam logic [33:0] E_WR    = 34'h200;
  localparam logic [33:0] E_RD    = 34'h400;
  localparam logic [33:0] E_BUS   = 34'h8000;
  localparam logic [33:0] E_ILL   = 34'h10000;
  localparam logic [33:0] E_HLT   = 34'h20000;

  logic clk, rst_n, run, acc_sign, mem_ready;
  logic [7:0] opcode;
  logic mem_rd, mem_wr, mar_ld, mar_sel, mbr_ld_mem, mbr_ld_acc, pc_inc, pc_ld, ir_ld, br_ld, acc_ld;
  logic [3:0] alu_op;
  logic halted, illegal, bus_err;
  logic [15:0] instr_count;
  logic [33:0] obs;
  logic [15:0] cnt;
  logic [33:0] exp_q[$];
  string tag_q[$];
  int total, bad;

  cpu_control_unit #(.OPC_W(8), .ALUOP_W(4), .TIMEOUT(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .opcode_i(opcode), .acc_sign_i(acc_sign),
    .mem_ready_i(mem_ready), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mar_ld_o(mar_ld),
    .mar_sel_o(mar_sel), .mbr_ld_mem_o(mbr_ld_mem), .mbr_ld_acc_o(mbr_ld_acc), .pc_inc_o(pc_inc),
    .pc_ld_o(pc_ld), .ir_ld_o(ir_ld), .br_ld_o(br_ld), .acc_ld_o(acc_ld), .alu_op_o(alu_op),
    .halted_o(halted), .illegal_o(illegal), .bus_err_o(bus_err), .instr_count_o(instr_count)
  );

  assign obs = {instr_count, halted, illegal, bus_err, alu_op, mem_rd, mem_wr, mar_ld, mar_sel,
                mbr_ld_mem, mbr_ld_acc, pc_inc, pc_ld, ir_ld, br_ld, acc_ld};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    logic [33:0] e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL %s: got %h want %h", t, obs, e);
        end
      end
    end
  end

  task automatic step(input logic r, input logic rdy, input logic sgn, input logic [7:0] op,
                      input logic [33:0] m, input string t);
    @(posedge clk);
    #1;
    run = r;
    mem_ready = rdy;
    acc_sign = sgn;
    opcode = op;
    exp_q.push_back(m | {cnt, 18'b0});
    tag_q.push_back(t);
  endtask

  task automatic rst_step(input string t);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    run = 1'b1;
    mem_ready = 1'b1;
    cnt = '0;
    exp_q.push_back(34'd0);
    tag_q.push_back(t);
  endtask

  task automatic go_step();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run = 1'b0;
    exp_q.push_back({cnt, 18'b0});
    tag_q.push_back("released");
  endtask

  task automatic fetch(input logic [7:0] op, input logic sgn);
    step(1, 1, sgn, op, E_MARLD, "f1");
    step(1, 1, sgn, op, E_RD | E_MBRM | E_PCINC, "f2");
    step(1, 1, sgn, op, E_IR | E_MARLD | E_MSEL, "f3");
    step(1, 1, sgn, op, 34'd0, "dec");
  endtask

  task automatic alu_instr(input logic [7:0] op, input logic [3:0] a, input logic mem, input logic rx);
    fetch(op, 1'b0);
    if (mem) begin
      step(1, 1, 0, op, E_RD | E_MBRM, "rd");
      step(1, 1, 0, op, E_BR, "brl");
    end
    step(rx, 1, 0, op, E_ACC | (34'(a) << 11), "ex");
    step(rx, 1, 0, op, 34'd0, "end");
    cnt++;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; acc_sign = 1'b0; mem_ready = 1'b0; opcode = 8'h00;
    cnt = '0; total = 0; bad = 0;
    rst_step("reset0");
    rst_step("reset1");
    go_step();
    step(1, 1, 0, 8'h01, 34'd0, "idle");
    alu_instr(8'h01, 4'd0, 1, 1);
    alu_instr(8'h03, 4'd1, 1, 1);
    alu_instr(8'h04, 4'd2, 1, 1);
    alu_instr(8'h08, 4'd3, 1, 1);
    alu_instr(8'h0A, 4'd5, 0, 1);
    alu_instr(8'h0B, 4'd6, 0, 1);
    alu_instr(8'h0C, 4'd7, 0, 1);
    fetch(8'h02, 0);
    step(1, 1, 0, 8'h02, E_MBRA, "wr1");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h02, E_WR, "wr2_wait");
    step(1, 1, 0, 8'h02, E_WR, "wr2_done");
    step(1, 1, 0, 8'h02, 34'd0, "st_end");
    cnt++;
    fetch(8'h06, 0);
    step(1, 1, 0, 8'h06, E_PCLD, "jgez_taken");
    step(1, 1, 0, 8'h06, 34'd0, "jgez_end");
    cnt++;
    fetch(8'h06, 1);
    step(1, 1, 1, 8'h06, 34'd0, "jgez_skip_end");
    cnt++;
    fetch(8'h05, 1);
    step(1, 1, 1, 8'h05, E_PCLD, "jmp");
    step(1, 1, 1, 8'h05, 34'd0, "jmp_end");
    cnt++;
    fetch(8'h00, 0);
    step(1, 1, 0, 8'h00, 34'd0, "nop_end");
    cnt++;
    alu_instr(8'h09, 4'd4, 1, 0);
    step(0, 1, 0, 8'h09, 34'd0, "idle_after_stop");
    step(0, 1, 0, 8'h09, 34'd0, "idle_after_stop2");
    step(1, 1, 0, 8'h01, 34'd0, "idle");
    fetch(8'h01, 0);
    step(1, 0, 0, 8'h01, E_RD, "rd_wait");
    rst_step("rst_in_rd");
    rst_step("rst_hold");
    go_step();
    step(1, 1, 0, 8'hFF, 34'd0, "idle");
    fetch(8'hFF, 0);
    for (int i = 0; i < 100; i++) step(1, 1, 0, 8'hFF, E_HLT | E_ILL, "illegal_hold");
    rst_step("flags_clear");
    go_step();
    step(1, 1, 0, 8'h0D, 34'd0, "idle");
    fetch(8'h0D, 0);
    cnt++;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 8'h0D, E_HLT, "halt_hold");
    rst_step("halt_clear");
    go_step();
    step(1, 0, 0, 8'h01, 34'd0, "idle");
    step(1, 0, 0, 8'h01, E_MARLD, "to_f1");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h01, E_RD, "to_f2_wait");
    for (int i = 0; i < 3; i++) step(1, 1, 0, 8'h01, E_HLT | E_BUS, "to_halted");
    rst_step("bus_clear");
    go_step();
    @(negedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
